// File: rtl/ecg_sample_writer.sv
// ecg_sample_writer: writer side of the ECG display RAM.
// Boxcar-averages groups of 2^LOG2_DECIM samples into display points and
// writes them into a DEPTH-word circular region at BASE_ADDR. The region is
// blanked after reset and on clear_req so the trace starts flat.
module ecg_sample_writer #(
  parameter logic [11:0] BASE_ADDR  = 12'h801,
  parameter int unsigned DEPTH      = 640,
  parameter int unsigned LOG2_DECIM = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_req,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [9:0]  wr_ptr,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned ACC_W = 12 + LOG2_DECIM;
  localparam int unsigned GRP_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'((1 << LOG2_DECIM) - 1);
  localparam logic [9:0] LAST_COL = 10'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t           state;
  logic [9:0]       clr_idx;
  logic [ACC_W-1:0] acc;
  logic [GRP_W-1:0] grp_cnt;

  logic             take;
  logic             grp_done;
  logic [ACC_W-1:0] sum;
  logic [11:0]      point;

  // Handshake and averaging datapath; acc is wide enough that sum never wraps
  assign sample_ready = (state == S_RUN) && enable && !clear_req;
  assign take         = sample_valid && sample_ready;
  assign grp_done     = (grp_cnt == GRP_LAST);
  assign sum          = acc + ACC_W'(sample_in);
  assign point        = 12'(sum >> LOG2_DECIM);
  assign busy         = (state == S_CLEAR);

  // Clear sweep, accumulation and registered RAM write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      clr_idx    <= '0;
      wr_ptr     <= '0;
      acc        <= '0;
      grp_cnt    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_CLEAR: begin
          mem_we    <= 1'b1;
          mem_addr  <= BASE_ADDR + 12'(clr_idx);
          mem_wdata <= '0;
          if (clr_idx == LAST_COL) begin
            clr_idx <= '0;
            state   <= S_RUN;
          end else begin
            clr_idx <= clr_idx + 10'd1;
          end
        end
        S_RUN: begin
          if (clear_req) begin
            // Partial group is discarded; sweep restarts from column 0
            state   <= S_CLEAR;
            clr_idx <= '0;
            wr_ptr  <= '0;
            acc     <= '0;
            grp_cnt <= '0;
          end else if (take) begin
            if (grp_done) begin
              acc       <= '0;
              grp_cnt   <= '0;
              mem_we    <= 1'b1;
              mem_addr  <= BASE_ADDR + 12'(wr_ptr);
              mem_wdata <= {20'b0, point};
              if (wr_ptr == LAST_COL) begin
                wr_ptr     <= '0;
                frame_done <= 1'b1;
              end else begin
                wr_ptr <= wr_ptr + 10'd1;
              end
            end else begin
              acc     <= sum;
              grp_cnt <= grp_cnt + GRP_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_sample_writer.sv
// tb_ecg_sample_writer: directed tests for ecg_sample_writer at default parameters.
module tb_ecg_sample_writer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        clear_req;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [9:0]  wr_ptr;
  logic        busy;
  logic        frame_done;

  int tests;
  int fails;

  ecg_sample_writer dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear_req    (clear_req),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .wr_ptr       (wr_ptr),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1; enable = 1'b1; clear_req = 1'b0;
    sample_valid = 1'b0; sample_in = 12'd0;
    tick; tick;
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b expected 0", mem_we); end
    tests++; if (mem_addr !== 12'h801) begin fails++; $display("FAIL rst_addr: got %h expected 801", mem_addr); end
    tests++; if (mem_wdata !== 32'd0) begin fails++; $display("FAIL rst_wdata: got %h expected 0", mem_wdata); end
    tests++; if (wr_ptr !== 10'd0) begin fails++; $display("FAIL rst_wr_ptr: got %0d expected 0", wr_ptr); end
    tests++; if (busy !== 1'b1 || sample_ready !== 1'b0) begin fails++; $display("FAIL rst_busy_ready: got %b%b expected 10", busy, sample_ready); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 640; k++) begin
      tick;
      if (mem_we !== 1'b1 || mem_addr !== 12'(32'h801 + k) || mem_wdata !== 32'd0) bad++;
      if (k < 639 && busy !== 1'b1) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL init_clear_sweep: got %0d bad beats expected 0", bad); end
    tick;
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL init_clear_end_we: got %b expected 0", mem_we); end
    tests++; if (busy !== 1'b0 || sample_ready !== 1'b1) begin fails++; $display("FAIL init_clear_end_busy_ready: got %b%b expected 01", busy, sample_ready); end
  endtask

  task automatic test_frame_wrap;
    int bad, nw, nfd, fd_at;
    bad = 0; nw = 0; nfd = 0; fd_at = -1;
    sample_in = 12'hFFF; sample_valid = 1'b1;
    for (int i = 0; i < 2560; i++) begin
      tick;
      if (mem_we !== ((i % 4) == 3)) bad++;
      if (mem_we === 1'b1) begin
        if (mem_addr !== 12'(32'h801 + nw) || mem_wdata !== 32'hFFF) bad++;
        if (frame_done === 1'b1) begin nfd++; fd_at = nw; end
        nw++;
      end else if (frame_done !== 1'b0) begin
        bad++;
      end
    end
    sample_valid = 1'b0;
    tests++; if (nw !== 640) begin fails++; $display("FAIL frame_write_count: got %0d expected 640", nw); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL frame_write_data: got %0d bad beats expected 0", bad); end
    tests++; if (nfd !== 1 || fd_at !== 639) begin fails++; $display("FAIL frame_done_pulse: got %0d pulses at write %0d expected 1 at 639", nfd, fd_at); end
    tests++; if (wr_ptr !== 10'd0) begin fails++; $display("FAIL frame_wrap_ptr: got %0d expected 0", wr_ptr); end
  endtask

  task automatic test_average;
    logic [11:0] v [4];
    int early;
    v[0] = 12'd100; v[1] = 12'd200; v[2] = 12'd300; v[3] = 12'd400;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      sample_in = v[i]; sample_valid = 1'b1;
      tick;
      if (i < 3 && mem_we !== 1'b0) early++;
    end
    sample_valid = 1'b0;
    tests++; if (early !== 0) begin fails++; $display("FAIL avg_early_write: got %0d writes expected 0", early); end
    tests++; if (mem_we !== 1'b1 || mem_addr !== 12'h801) begin fails++; $display("FAIL avg_write: got we=%b addr=%h expected we=1 addr=801", mem_we, mem_addr); end
    tests++; if (mem_wdata !== 32'd250) begin fails++; $display("FAIL avg_value: got %0d expected 250", mem_wdata); end
    tests++; if (wr_ptr !== 10'd1) begin fails++; $display("FAIL avg_wr_ptr: got %0d expected 1", wr_ptr); end
    tick;
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL avg_single_write: got %b expected 0", mem_we); end
  endtask

  task automatic test_freeze;
    int bad;
    bad = 0;
    sample_in = 12'd20; sample_valid = 1'b1;
    tick; tick;
    sample_in = 12'd10; enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (sample_ready !== 1'b0) bad++;
      tick;
      if (mem_we !== 1'b0 || wr_ptr !== 10'd1) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL freeze_hold: got %0d bad cycles expected 0", bad); end
    enable = 1'b1;
    tick;
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL freeze_resume_partial: got %b expected 0", mem_we); end
    tick;
    sample_valid = 1'b0;
    tests++; if (mem_we !== 1'b1 || mem_addr !== 12'h802 || mem_wdata !== 32'd15) begin
      fails++; $display("FAIL freeze_resume_write: got we=%b addr=%h data=%0d expected we=1 addr=802 data=15", mem_we, mem_addr, mem_wdata);
    end
    tests++; if (wr_ptr !== 10'd2) begin fails++; $display("FAIL freeze_wr_ptr: got %0d expected 2", wr_ptr); end
  endtask

  task automatic test_clear_req;
    logic [11:0] v [4];
    int bad;
    for (int i = 1; i <= 3; i++) begin
      sample_in = 12'(i); sample_valid = 1'b1;
      tick;
    end
    sample_in = 12'd4; clear_req = 1'b1;
    #1;
    tests++; if (sample_ready !== 1'b0) begin fails++; $display("FAIL clrreq_ready: got %b expected 0", sample_ready); end
    tick;
    clear_req = 1'b0; sample_valid = 1'b0;
    tests++; if (busy !== 1'b1 || mem_we !== 1'b0 || wr_ptr !== 10'd0) begin
      fails++; $display("FAIL clrreq_enter: got busy=%b we=%b ptr=%0d expected busy=1 we=0 ptr=0", busy, mem_we, wr_ptr);
    end
    bad = 0;
    for (int k = 0; k < 640; k++) begin
      if (sample_ready !== 1'b0) bad++;
      tick;
      if (mem_we !== 1'b1 || mem_addr !== 12'(32'h801 + k) || mem_wdata !== 32'd0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL clrreq_sweep: got %0d bad beats expected 0", bad); end
    v[0] = 12'd40; v[1] = 12'd80; v[2] = 12'd120; v[3] = 12'd160;
    for (int i = 0; i < 4; i++) begin
      sample_in = v[i]; sample_valid = 1'b1;
      tick;
    end
    sample_valid = 1'b0;
    tests++; if (mem_we !== 1'b1 || mem_addr !== 12'h801 || mem_wdata !== 32'd100) begin
      fails++; $display("FAIL clrreq_next_group: got we=%b addr=%h data=%0d expected we=1 addr=801 data=100", mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_async_reset;
    int bad;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      tick;
      if (mem_we !== 1'b1 || mem_addr !== 12'(32'h801 + k)) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL areset_pre_sweep: got %0d bad beats expected 0", bad); end
    #2;
    reset = 1'b1;
    #1;
    tests++; if (mem_we !== 1'b0 || mem_addr !== 12'h801) begin
      fails++; $display("FAIL areset_immediate: got we=%b addr=%h expected we=0 addr=801", mem_we, mem_addr);
    end
    tests++; if (busy !== 1'b1 || wr_ptr !== 10'd0) begin fails++; $display("FAIL areset_state: got busy=%b ptr=%0d expected busy=1 ptr=0", busy, wr_ptr); end
    tick;
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 640; k++) begin
      tick;
      if (mem_we !== 1'b1 || mem_addr !== 12'(32'h801 + k) || mem_wdata !== 32'd0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL areset_restart_sweep: got %0d bad beats expected 0", bad); end
    tick;
    tests++; if (mem_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL areset_sweep_end: got we=%b busy=%b expected 0 0", mem_we, busy); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_frame_wrap;
    test_average;
    test_freeze;
    test_clear_req;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecg_sample_writer.md
Name: ecg_sample_writer

Overview:
Writer side of the ECG display RAM. Accepts a stream of 12-bit ECG samples over a valid/ready handshake and boxcar-averages each group of 2^LOG2_DECIM samples into one display point. Each point is written into a 640-entry circular region starting at BASE_ADDR, which the VGA controller reads one word per pixel column. The block also clears the region after reset and on request, so the trace starts flat.

Parameters:
BASE_ADDR, 12'h801, first RAM word of the display region (pixel column 0)
DEPTH, 640, number of display words (one per pixel column)
LOG2_DECIM, 2, log2 of input samples averaged per display point (0 = no averaging)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  run/freeze; low freezes acquisition (no samples accepted)
clear_req  input  1  single-cycle request to blank the display region
sample_in  input  12  ECG sample, unsigned
sample_valid  input  1  sample_in valid this cycle
sample_ready  output  1  block accepts sample_in this cycle
mem_addr  output  12  RAM write address
mem_wdata  output  32  RAM write data, {20'b0, point[11:0]}
mem_we  output  1  RAM write enable, one word per asserted cycle
wr_ptr  output  10  next display column to be written, 0..DEPTH-1
busy  output  1  high while clearing
frame_done  output  1  one-cycle pulse when column DEPTH-1 is written

Behaviour:
- Reset (async): state=CLEAR, clr_idx=0, wr_ptr=0, acc=0, grp_cnt=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, frame_done=0.
  - Outputs then follow the CLEAR sequence below.
  - Asserting reset mid-write or mid-clear aborts immediately; the sequence restarts from column 0.
- States: CLEAR, RUN.
- CLEAR: each cycle, registered mem_we=1, mem_addr=BASE_ADDR+clr_idx, mem_wdata=0, clr_idx++.
  - After the write with clr_idx=DEPTH-1, go to RUN. Exactly DEPTH writes occur, covering 0x801..0xA80 at the defaults.
  - busy=1 and sample_ready=0 throughout CLEAR.
  - clear_req during CLEAR is ignored; the clear does not restart.
- RUN, handshake: sample_ready = (state==RUN) && enable && !clear_req, combinational.
  - A transfer occurs when sample_valid && sample_ready.
  - sample_in must be held stable while valid and not ready.
- RUN, accumulate: on transfer, acc += sample_in and grp_cnt++.
  - acc is 12+LOG2_DECIM bits wide, so it never overflows.
  - On the transfer where grp_cnt==2^LOG2_DECIM-1, the point = (acc + sample_in) >> LOG2_DECIM, truncated. acc and grp_cnt then reset to 0.
- RUN, write latency: exactly 1 cycle after the completing transfer, registered outputs show mem_we=1, mem_addr=BASE_ADDR+wr_ptr, mem_wdata={20'b0, point}.
  - wr_ptr increments in the same cycle.
  - Full throughput: one sample per cycle; a write can coincide with the next accepted sample.
- Wrap: when the written column is DEPTH-1, wr_ptr returns to 0 and frame_done=1 in the same cycle as that mem_we.
- Freeze: when enable is low, acc, grp_cnt and wr_ptr are held. A write already scheduled from the previous cycle still completes.
- Clear request: clear_req in RUN, in the next cycle:
  - Enter CLEAR; any pending write from the previous cycle is issued first, and CLEAR starts the cycle after.
  - wr_ptr=0, acc=0, grp_cnt=0; the partial group is discarded.
  - A sample presented in the clear_req cycle is not accepted.
- mem_we=0 in every cycle not listed above; mem_addr and mem_wdata hold their last values.

Test Plan:
1. Reset release -> mem_we high for 640 consecutive cycles, addresses 0x801..0xA80, data 0; busy falls and sample_ready rises on cycle 641.
2. LOG2_DECIM=2, samples 100,200,300,400 on consecutive cycles -> a single write of 250 to 0x801 one cycle after the 4th sample; wr_ptr=1.
3. Sample 4095 repeated 2560 times -> 640 writes of 0xFFF; frame_done pulses with the write to 0xA80; the next group writes 0x801.
4. enable low after 2 of 4 samples for 10 cycles with sample_valid high -> sample_ready=0 and no writes; after re-enable, 2 more samples (10,10 after 20,20) -> write of 15.
5. clear_req after 3 samples, with sample_valid high -> sample not accepted, busy=1, 640 zero writes, then the next 4 samples write to 0x801.
6. Async reset asserted mid-clear at clr_idx=300 -> mem_we drops immediately; after release the clear restarts at 0x801.
